// File: rtl/calc_mini_pkg.sv
// Shared types and constants for the calc_mini blocks.
// Holds the divider FSM state encoding and the default operand width.
package calc_mini_pkg;

   localparam int unsigned CALC_MINI_BW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } calc_mini_state_t;

   // Iteration counter width; at least one bit so BW = 1 still elaborates.
   function automatic int unsigned calc_mini_cnt_w(input int unsigned bw);
      return (bw > 1) ? $clog2(bw) : 1;
   endfunction

endpackage

// File: rtl/calc_mini_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module calc_mini_div_step
   import calc_mini_pkg::*;
#(
   parameter int unsigned BW = CALC_MINI_BW
) (
   input  logic [BW-1:0] rem_i,
   input  logic          dvd_bit_i,
   input  logic [BW-1:0] dvs_i,
   output logic [BW-1:0] rem_c,
   output logic          q_bit_c
);

   logic [BW:0]   shift;
   logic [BW+1:0] diff;

   // Remainder is always below the divisor, so the kept value fits in BW bits.
   always_comb begin
      shift   = {rem_i, dvd_bit_i};
      diff    = {1'b0, shift} - {2'b00, dvs_i};
      q_bit_c = ~diff[BW+1];
      rem_c   = q_bit_c ? BW'(diff) : BW'(shift);
   end

endmodule

// File: rtl/calc_mini_div.sv
// Multi-cycle unsigned divider with valid/ready handshakes on both sides.
// Define CALC_MINI_DIV_CHECK_EN to add the chk_err self-check output.
module calc_mini_div
   import calc_mini_pkg::*;
#(
   parameter int unsigned BW = CALC_MINI_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] a,
   input  logic [BW-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] q,
   output logic [BW-1:0] r,
   output logic          div_zero
`ifdef CALC_MINI_DIV_CHECK_EN
   ,
   output logic          chk_err
`endif
);

   localparam int unsigned CW = calc_mini_cnt_w(BW);

   calc_mini_state_t state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    dvd_q, dvd_d;
   logic [BW-1:0]    dvs_q, dvs_d;
   logic [BW-1:0]    rem_q, rem_d;
   logic [BW-1:0]    quo_q, quo_d;
   logic             dz_q, dz_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [BW-1:0]    step_rem;
   logic             step_q_bit;

   calc_mini_div_step #(.BW(BW)) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[cnt_q]),
      .dvs_i     (dvs_q),
      .rem_c     (step_rem),
      .q_bit_c   (step_q_bit)
   );

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dz_d    = dz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               dvd_d = a;
               dvs_d = b;
               if (b == '0) begin
                  quo_d   = '1;
                  rem_d   = a;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = '0;
                  rem_d   = '0;
                  dz_d    = 1'b0;
                  cnt_d   = CW'(BW - 1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d = step_rem;
            quo_d = BW'({quo_q, step_q_bit});
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dz_q        <= dz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign q         = quo_q;
   assign r         = rem_q;
   assign div_zero  = dz_q;

`ifdef CALC_MINI_DIV_CHECK_EN
   localparam int unsigned PW = 2 * BW;

   logic [PW-1:0] chk_prod;
   logic          chk_err_q, chk_err_d;

   // Recompose q*b + r from the values the result will hold in DONE.
   always_comb begin
      chk_prod  = PW'(quo_d) * PW'(dvs_d) + PW'(rem_d);
      chk_err_d = (state_d == DONE) && !dz_d &&
                  ((chk_prod != PW'(dvd_d)) || (rem_d >= dvs_d));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err_q <= 1'b0;
      end else begin
         chk_err_q <= chk_err_d;
      end
   end

   assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_calc_mini_div.sv
// Scoreboard bench for calc_mini_div: directed corner cases plus randomized
// traffic with random backpressure and junk inputs while busy.
module tb_calc_mini_div;

   localparam int unsigned BW = 8;

   typedef struct packed {
      logic [BW-1:0] q;
      logic [BW-1:0] r;
      logic          dz;
      logic [7:0]    lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [BW-1:0] a = '0;
   logic [BW-1:0] b = '0;
   logic          in_ready;
   logic          out_valid;
   logic [BW-1:0] q;
   logic [BW-1:0] r;
   logic          div_zero;
`ifdef CALC_MINI_DIV_CHECK_EN
   logic          chk_err;
`endif

   calc_mini_div #(.BW(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .r         (r),
      .div_zero  (div_zero)
`ifdef CALC_MINI_DIV_CHECK_EN
      ,
      .chk_err   (chk_err)
`endif
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   exp_t cur;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic busy = 1'b0;
   logic armed = 1'b0;
   logic rst_d1 = 1'b0;
   logic showing = 1'b0;
   logic tmo_req = 1'b0;
   logic tmo_seen = 1'b0;

   // Reference: plain integer division, with the divide-by-zero convention.
   function automatic exp_t model(input logic [BW-1:0] x, input logic [BW-1:0] y);
      exp_t e;
      if (y == '0) begin
         e.q   = '1;
         e.r   = x;
         e.dz  = 1'b1;
         e.lat = 8'd1;
      end else begin
         e.q   = x / y;
         e.r   = x % y;
         e.dz  = 1'b0;
         e.lat = 8'(BW + 1);
      end
      return e;
   endfunction

   // Observe handshakes at the edge and record expected results.
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_d1 <= rst;
      if (rst) begin
         armed <= 1'b1;
         busy  <= 1'b0;
         exp_q.delete();
      end else if (!busy && in_valid && in_ready) begin
         busy    <= 1'b1;
         acc_cyc <= cyc + 1;
         exp_q.push_back(model(a, b));
      end else if (busy && out_valid && out_ready) begin
         busy <= 1'b0;
      end
   end

   // Monitor: compare DUT outputs against the scoreboard away from the edge.
   always @(negedge clk) begin
      if (armed) begin
         logic [7:0] lat;
         logic       exp_ov;
         if (rst_d1) begin
            checks++;
            if (out_valid !== 1'b0 || q !== '0 || r !== '0 || div_zero !== 1'b0) begin
               errors++;
               $display("FAIL reset_outputs: out_valid=%b q=%0d r=%0d dz=%b, expected all zero",
                        out_valid, q, r, div_zero);
            end
         end
         checks++;
         if (in_ready !== !busy) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (cycle %0d)", in_ready, !busy, cyc);
         end
         if (!busy) begin
            showing = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL out_valid_idle: got %b expected 0 (cycle %0d)", out_valid, cyc);
            end
         end else if (!showing && exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: busy with no expected result (cycle %0d)", cyc);
         end else begin
            lat    = showing ? cur.lat : exp_q[0].lat;
            exp_ov = ((cyc - acc_cyc + 1) >= int'(lat));
            checks++;
            if (out_valid !== exp_ov) begin
               errors++;
               $display("FAIL out_valid_timing: got %b expected %b at %0d cycles after accept",
                        out_valid, exp_ov, cyc - acc_cyc + 1);
            end
            if (out_valid === 1'b1 && exp_ov) begin
               if (!showing) begin
                  cur     = exp_q.pop_front();
                  showing = 1'b1;
               end
               checks++;
               if (q !== cur.q || r !== cur.r || div_zero !== cur.dz) begin
                  errors++;
                  $display("FAIL result: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                           q, r, div_zero, cur.q, cur.r, cur.dz);
               end
`ifdef CALC_MINI_DIV_CHECK_EN
               checks++;
               if (chk_err !== 1'b0) begin
                  errors++;
                  $display("FAIL chk_err: got %b expected 0", chk_err);
               end
`endif
            end
         end
         if (tmo_req && !tmo_seen) begin
            tmo_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL timeout: in_ready did not return within the cycle budget");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready while presenting junk that must be ignored.
   task automatic wait_ready(input bit rnd_ordy);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 300) begin
         in_valid = 1'($urandom_range(0, 1));
         a        = BW'($urandom);
         b        = BW'($urandom);
         if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (n >= 300) tmo_req = 1'b1;
   endtask

   task automatic issue(input logic [BW-1:0] x, input logic [BW-1:0] y, input bit rnd_ordy);
      wait_ready(rnd_ordy);
      a        = x;
      b        = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      issue(8'd200, 8'd7,   1'b0);
      issue(8'd5,   8'd0,   1'b0);
      issue(8'd9,   8'd3,   1'b0);
      issue(8'd255, 8'd1,   1'b0);
      issue(8'd3,   8'd10,  1'b0);
      issue(8'd0,   8'd255, 1'b0);
      wait_ready(1'b0);

      // Backpressure: hold the result for several cycles, then a one-cycle pulse.
      out_ready = 1'b0;
      issue(8'd100, 8'd9, 1'b0);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) tmo_req = 1'b1;
      repeat (5) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      out_ready = 1'b1;

      // Reset in the fourth RUN cycle aborts the operation.
      issue(8'd123, 8'd5, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      issue(8'd50, 8'd6, 1'b0);
      wait_ready(1'b0);

      for (int i = 0; i < 1000; i++) begin
         issue(BW'($urandom), BW'($urandom_range(1, 255)), 1'b1);
      end
      for (int i = 0; i < 60; i++) begin
         issue(BW'($urandom), BW'($urandom_range(0, 3)), 1'b1);
      end
      out_ready = 1'b1;
      wait_ready(1'b0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
